// File: rtl/dac_spi_output_if.sv
// Bundle between the summing tree, the DAC output stage and the external DAC.
// The master modport is the upstream side (sample source, status observer).
// The slave modport is the output stage, which drives the SPI pins and status.
interface dac_spi_output_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  logic signed [15:0] sample;
  logic               sample_active;
  logic               dac_sclk;
  logic               dac_cs_n;
  logic               dac_mosi;
  logic               busy;
  logic               overflow;
  logic [LW-1:0]      fifo_level;

  modport master (
    output sample, sample_active,
    input  dac_sclk, dac_cs_n, dac_mosi, busy, overflow, fifo_level
  );

  modport slave (
    input  sample, sample_active,
    output dac_sclk, dac_cs_n, dac_mosi, busy, overflow, fifo_level
  );
endinterface

// File: rtl/dac_spi_output.sv
// DAC output stage: decimates the mixed sample stream to one capture per
// SAMPLE_DIV clocks, buffers captures in a small FIFO as offset binary, and
// shifts each one MSB-first to a 16-bit SPI DAC (SCLK idles low, data changes
// on falling SCLK, DAC samples on rising SCLK).
module dac_spi_output #(
  parameter int SAMPLE_DIV = 256,
  parameter int CLKDIV     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  dac_spi_output_if.slave bus
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int HW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic          w_push;
  logic          w_full;
  logic          w_accept;
  logic          w_pop;
  logic [15:0]   w_head;

  logic [HW-1:0] r_hp_cnt;
  logic [3:0]    r_bit_cnt;
  logic [15:0]   r_shift;
  logic          r_sclk;
  logic          r_cs_n;
  logic          r_mosi;
  logic          w_hp_tc;
  logic          w_last_fall;

  assign w_tick      = (r_tick_cnt == TW'(SAMPLE_DIV - 1));
  assign w_push      = w_tick && bus.sample_active;
  assign w_full      = (r_level == LW'(FIFO_DEPTH));
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_accept    = w_push && (!w_full || w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_hp_tc     = (r_hp_cnt == HW'(CLKDIV - 1));
  // The falling toggle that completes the 16th bit ends the frame.
  assign w_last_fall = w_hp_tc && r_sclk && (r_bit_cnt == 4'd15);

  // Sample-period counter; tick marks the last clk of each period.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + TW'(1);
    end
  end

  // Sample storage, written in offset binary (sign bit inverted).
  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and level, so stale contents are never read out.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= {~bus.sample[15], bus.sample[14:0]};
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)    r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      case ({w_accept, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next state and the pop request.
  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT:   if (w_last_fall) w_next_state = GAP;
      GAP:     if (w_hp_tc)     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // SPI datapath: load on pop, toggle SCLK every CLKDIV clocks, shift on falls.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_mosi    <= 1'b0;
      r_hp_cnt  <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_hp_cnt <= '0;
          if (w_pop) begin
            r_shift   <= w_head;
            r_mosi    <= w_head[15];
            r_cs_n    <= 1'b0;
            r_sclk    <= 1'b0;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (w_hp_tc) begin
            r_hp_cnt <= '0;
            r_sclk   <= ~r_sclk;
            if (r_sclk) begin
              if (r_bit_cnt == 4'd15) begin
                r_cs_n <= 1'b1;
                r_mosi <= 1'b0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {r_shift[14:0], 1'b0};
                r_mosi    <= r_shift[14];
              end
            end
          end else begin
            r_hp_cnt <= r_hp_cnt + HW'(1);
          end
        end
        GAP: begin
          if (w_hp_tc) r_hp_cnt <= '0;
          else         r_hp_cnt <= r_hp_cnt + HW'(1);
        end
        default: r_hp_cnt <= '0;
      endcase
    end
  end

  assign bus.dac_sclk   = r_sclk;
  assign bus.dac_cs_n   = r_cs_n;
  assign bus.dac_mosi   = r_mosi;
  assign bus.busy       = (r_state != IDLE);
  assign bus.overflow   = r_overflow;
  assign bus.fifo_level = r_level;

endmodule

// File: tb/tb_dac_spi_output.sv
// Directed bench for dac_spi_output. Instance A uses default parameters;
// instances B and C use SAMPLE_DIV=8, CLKDIV=4 to fill the FIFO quickly.
module tb_dac_spi_output;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dac_spi_output_if #(.FIFO_DEPTH(4)) if_a ();
  dac_spi_output_if #(.FIFO_DEPTH(4)) if_b ();
  dac_spi_output_if #(.FIFO_DEPTH(4)) if_c ();

  dac_spi_output #(.SAMPLE_DIV(256), .CLKDIV(4), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .reset(rst_a), .bus(if_a));
  dac_spi_output #(.SAMPLE_DIV(8), .CLKDIV(4), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .reset(rst_b), .bus(if_b));
  dac_spi_output #(.SAMPLE_DIV(8), .CLKDIV(4), .FIFO_DEPTH(4)) u_dut_c (
    .clk(clk), .reset(rst_c), .bus(if_c));

  // SPI receive monitors: shift MOSI on each rising SCLK while CS is low,
  // record the word, CS-low length and rise count when CS returns high.
  logic [15:0] frames_a[$];
  int          lows_a[$];
  int          rises_a[$];
  logic [15:0] frames_b[$];
  logic [15:0] mon_a_sh, mon_b_sh;
  int          mon_a_low, mon_a_rises;
  logic        mon_a_pcs = 1'b1, mon_a_psclk = 1'b0;
  logic        mon_b_pcs = 1'b1, mon_b_psclk = 1'b0;
  int          max_lvl_a = 0;

  always @(negedge clk) begin
    if (!if_a.dac_cs_n) begin
      if (mon_a_pcs) begin
        mon_a_sh = '0; mon_a_low = 0; mon_a_rises = 0;
      end
      mon_a_low++;
      if (if_a.dac_sclk && !mon_a_psclk) begin
        mon_a_sh = {mon_a_sh[14:0], if_a.dac_mosi};
        mon_a_rises++;
      end
    end else if (!mon_a_pcs) begin
      frames_a.push_back(mon_a_sh);
      lows_a.push_back(mon_a_low);
      rises_a.push_back(mon_a_rises);
    end
    if (int'(if_a.fifo_level) > max_lvl_a) max_lvl_a = int'(if_a.fifo_level);
    mon_a_pcs   = if_a.dac_cs_n;
    mon_a_psclk = if_a.dac_sclk;
  end

  always @(negedge clk) begin
    if (!if_b.dac_cs_n) begin
      if (mon_b_pcs) mon_b_sh = '0;
      if (if_b.dac_sclk && !mon_b_psclk) mon_b_sh = {mon_b_sh[14:0], if_b.dac_mosi};
    end else if (!mon_b_pcs) begin
      frames_b.push_back(mon_b_sh);
    end
    mon_b_pcs   = if_b.dac_cs_n;
    mon_b_psclk = if_b.dac_sclk;
  end

  task automatic clear_a();
    frames_a.delete(); lows_a.delete(); rises_a.delete();
    max_lvl_a = 0;
  endtask

  // Reset A; the last reset edge is cycle 0 for the caller's edge count.
  task automatic reset_a();
    @(negedge clk); rst_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_a = 1'b0;
    clear_a();
  endtask

  task automatic wait_frames_a(input int n, input int budget);
    for (int i = 0; i < budget && frames_a.size() < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    if_a.sample = '0; if_a.sample_active = 1'b0;
    if_b.sample = '0; if_b.sample_active = 1'b0;
    if_c.sample = '0; if_c.sample_active = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (if_a.dac_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", if_a.dac_sclk); end
    checks++; if (if_a.dac_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", if_a.dac_cs_n); end
    checks++; if (if_a.dac_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", if_a.dac_mosi); end
    checks++; if (if_a.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", if_a.busy); end
    checks++; if (if_a.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", if_a.overflow); end
    checks++; if (if_a.fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", if_a.fifo_level); end
  endtask

  task automatic test_first_frame();
    int early = 0;
    if_a.sample = 16'h0000; if_a.sample_active = 1'b1;
    reset_a();
    for (int n = 1; n <= 257; n++) begin
      @(posedge clk); @(negedge clk);
      if (n < 257 && if_a.dac_cs_n !== 1'b1) early++;
      if (n == 256) begin
        checks++; if (if_a.fifo_level !== 3'd1) begin failures++; $display("FAIL ff_level_after_tick got=%0d exp=1", if_a.fifo_level); end
      end
      if (n == 257) begin
        checks++; if (if_a.dac_cs_n !== 1'b0) begin failures++; $display("FAIL ff_cs_fall_latency got=%b exp=0", if_a.dac_cs_n); end
        checks++; if (if_a.dac_mosi !== 1'b1 || if_a.dac_sclk !== 1'b0 || if_a.busy !== 1'b1)
          begin failures++; $display("FAIL ff_frame_start mosi/sclk/busy got=%b%b%b exp=101", if_a.dac_mosi, if_a.dac_sclk, if_a.busy); end
      end
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL ff_cs_early got=%0d exp=0", early); end
    wait_frames_a(1, 200);
    checks++;
    if (frames_a.size() < 1) begin
      failures++; $display("FAIL ff_frame_timeout got=0 frames exp=1");
    end else begin
      if (frames_a[0] !== 16'h8000) begin failures++; $display("FAIL ff_data got=%h exp=8000", frames_a[0]); end
      checks++; if (lows_a[0] !== 128) begin failures++; $display("FAIL ff_cs_low_len got=%0d exp=128", lows_a[0]); end
      checks++; if (rises_a[0] !== 16) begin failures++; $display("FAIL ff_sclk_rises got=%0d exp=16", rises_a[0]); end
    end
  endtask

  task automatic test_sample_values();
    logic [15:0] exp_v [3] = '{16'h0000, 16'hFFFF, 16'h7FFF};
    if_a.sample = 16'h8000; if_a.sample_active = 1'b1;
    reset_a();
    for (int n = 1; n <= 768; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 256) if_a.sample = 16'h7FFF;
      if (n == 512) if_a.sample = 16'hFFFF;
      if (n == 768) if_a.sample_active = 1'b0;
    end
    wait_frames_a(3, 300);
    checks++;
    if (frames_a.size() < 3) begin
      failures++; $display("FAIL sv_frames_timeout got=%0d exp=3", frames_a.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (frames_a[i] !== exp_v[i]) begin failures++; $display("FAIL sv_data[%0d] got=%h exp=%h", i, frames_a[i], exp_v[i]); end
      end
    end
    checks++; if (max_lvl_a !== 1) begin failures++; $display("FAIL sv_max_level got=%0d exp=1", max_lvl_a); end
  endtask

  task automatic test_inactive();
    int bad = 0;
    if_a.sample_active = 1'b0;
    repeat (10) @(negedge clk);
    clear_a();
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); @(negedge clk);
      if (if_a.dac_cs_n !== 1'b1 || if_a.busy !== 1'b0 || if_a.fifo_level !== 3'd0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL inactive_quiet got=%0d busy cycles exp=0", bad); end
    checks++; if (frames_a.size() !== 0) begin failures++; $display("FAIL inactive_frames got=%0d exp=0", frames_a.size()); end
  endtask

  task automatic test_reset_mid_frame();
    int rises = 0;
    int at_n = 0;
    int early = 0;
    logic psclk = 1'b0;
    if_a.sample = 16'h1234; if_a.sample_active = 1'b1;
    reset_a();
    for (int n = 1; n <= 600 && rises < 7; n++) begin
      @(posedge clk); @(negedge clk);
      if (!if_a.dac_cs_n && if_a.dac_sclk && !psclk) begin rises++; at_n = n; end
      psclk = if_a.dac_sclk;
    end
    checks++; if (at_n !== 309) begin failures++; $display("FAIL mr_seventh_rise_cycle got=%0d exp=309", at_n); end
    rst_a = 1'b1; if_a.sample_active = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_a = 1'b0;
    checks++;
    if (if_a.dac_cs_n !== 1'b1 || if_a.dac_sclk !== 1'b0 || if_a.busy !== 1'b0 || if_a.fifo_level !== 3'd0)
      begin failures++; $display("FAIL mr_abort cs/sclk/busy/level got=%b%b%b/%0d exp=100/0",
        if_a.dac_cs_n, if_a.dac_sclk, if_a.busy, if_a.fifo_level); end
    for (int n = 1; n <= 513; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 10) clear_a();
      if (n == 300) if_a.sample_active = 1'b1;
      if (n < 513 && if_a.dac_cs_n !== 1'b1) early++;
      if (n == 512) begin
        checks++; if (if_a.fifo_level !== 3'd1) begin failures++; $display("FAIL mr_fresh_level got=%0d exp=1", if_a.fifo_level); end
      end
      if (n == 513) begin
        checks++; if (if_a.dac_cs_n !== 1'b0) begin failures++; $display("FAIL mr_fresh_cs got=%b exp=0", if_a.dac_cs_n); end
      end
    end
    checks++; if (early !== 0) begin failures++; $display("FAIL mr_no_frame_before_capture got=%0d exp=0", early); end
    if_a.sample_active = 1'b0;
    wait_frames_a(1, 200);
    checks++;
    if (frames_a.size() < 1) begin failures++; $display("FAIL mr_frame_timeout got=0 exp=1"); end
    else if (frames_a[0] !== 16'h9234) begin failures++; $display("FAIL mr_data got=%h exp=9234", frames_a[0]); end
  endtask

  // SAMPLE_DIV=8: ticks push at cycles 8k, frames start at 9, 142, 275, 408, 541.
  task automatic test_overflow();
    if_b.sample = 16'd1; if_b.sample_active = 1'b1;
    frames_b.delete();
    @(negedge clk); rst_b = 1'b0;
    for (int n = 1; n <= 700; n++) begin
      @(posedge clk); @(negedge clk);
      if (n % 8 == 0) if_b.sample = 16'(n / 8 + 1);
      if (n == 40) begin
        checks++; if (if_b.fifo_level !== 3'd4 || if_b.overflow !== 1'b0)
          begin failures++; $display("FAIL ov_full level/ovf got=%0d/%b exp=4/0", if_b.fifo_level, if_b.overflow); end
      end
      if (n == 48) begin
        checks++; if (if_b.fifo_level !== 3'd4 || if_b.overflow !== 1'b1)
          begin failures++; $display("FAIL ov_set level/ovf got=%0d/%b exp=4/1", if_b.fifo_level, if_b.overflow); end
      end
      if (n == 700) begin
        checks++; if (if_b.overflow !== 1'b1) begin failures++; $display("FAIL ov_sticky got=%b exp=1", if_b.overflow); end
      end
    end
    checks++;
    if (frames_b.size() < 5) begin
      failures++; $display("FAIL ov_frames_timeout got=%0d exp=5", frames_b.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (frames_b[i] !== 16'h8000 + 16'(i + 1))
          begin failures++; $display("FAIL ov_order[%0d] got=%h exp=%h", i, frames_b[i], 16'h8000 + 16'(i + 1)); end
      end
    end
  endtask

  // Captures only on ticks 1-5, 18, 35, 51; tick 51 (cycle 408) meets the IDLE pop with the FIFO full.
  task automatic test_push_pop_full();
    if_c.sample = 16'd1; if_c.sample_active = 1'b1;
    @(negedge clk); rst_c = 1'b0;
    for (int n = 1; n <= 420; n++) begin
      @(posedge clk); @(negedge clk);
      if (n % 8 == 0) begin
        if_c.sample = 16'(n / 8 + 1);
        case (n / 8 + 1)
          1, 2, 3, 4, 5, 18, 35, 51: if_c.sample_active = 1'b1;
          default:                   if_c.sample_active = 1'b0;
        endcase
      end
      if (n == 48) begin
        checks++; if (if_c.fifo_level !== 3'd4 || if_c.overflow !== 1'b0)
          begin failures++; $display("FAIL pp_full level/ovf got=%0d/%b exp=4/0", if_c.fifo_level, if_c.overflow); end
      end
      if (n == 142) begin
        checks++; if (if_c.fifo_level !== 3'd3) begin failures++; $display("FAIL pp_pop_only got=%0d exp=3", if_c.fifo_level); end
      end
      if (n == 407) begin
        checks++; if (if_c.fifo_level !== 3'd4 || if_c.busy !== 1'b0)
          begin failures++; $display("FAIL pp_pre level/busy got=%0d/%b exp=4/0", if_c.fifo_level, if_c.busy); end
      end
      if (n == 408) begin
        checks++; if (if_c.fifo_level !== 3'd4 || if_c.overflow !== 1'b0 || if_c.busy !== 1'b1)
          begin failures++; $display("FAIL pp_coincide level/ovf/busy got=%0d/%b/%b exp=4/0/1",
            if_c.fifo_level, if_c.overflow, if_c.busy); end
      end
      if (n == 420) begin
        checks++; if (if_c.overflow !== 1'b0) begin failures++; $display("FAIL pp_no_overflow got=%b exp=0", if_c.overflow); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_sample_values();
    test_inactive();
    test_reset_mid_frame();
    test_overflow();
    test_push_pop_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_output.md
Name: dac_spi_output

Overview:
- Output stage directly downstream of the 64-channel summing tree; consumes its signed 16-bit mixed sample and active flag.
- Decimates the per-clock result to a fixed sample rate and buffers samples in a small FIFO.
- Converts each sample to offset binary and shifts it MSB-first to an external 16-bit SPI DAC.

Parameters:
- SAMPLE_DIV, 256, clk cycles per sample period (>=2); one capture per period.
- CLKDIV, 4, clk cycles per SCLK half-period (>=1).
- FIFO_DEPTH, 4, sample FIFO entries (power of 2, >=2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample  input  16  signed two's-complement mixed sample from summing tree.
- sample_active  input  1  high when sample is valid.
- dac_sclk  output  1  SPI clock, idles low.
- dac_cs_n  output  1  SPI chip select, active low.
- dac_mosi  output  1  SPI data, MSB first.
- busy  output  1  high while a frame is in progress (state != IDLE).
- overflow  output  1  sticky: a capture was dropped because the FIFO was full.
- fifo_level  output  clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Interface fixed: one clock, clk; reset is synchronous and active-high, named reset.

Behaviour:
- Reset (clk edge with reset=1): dac_sclk=0, dac_cs_n=1, dac_mosi=0, busy=0, overflow=0, fifo_level=0, tick counter=0, FSM=IDLE. Reset mid-frame aborts the frame on that edge and empties the FIFO.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps. tick=1 in the cycle where count==SAMPLE_DIV-1.
- Capture: on a tick cycle with sample_active=1, push {~sample[15], sample[14:0]} (offset binary). On a tick with sample_active=0, nothing is pushed.
- Push while full: the sample is dropped and overflow is set, unless a pop occurs in the same cycle. Simultaneous push and pop is accepted and fifo_level is unchanged. overflow clears only on reset.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - If fifo_level!=0: pop the head into a 16-bit shift register; on the next edge dac_cs_n=0, dac_mosi=bit15, dac_sclk=0, go to SHIFT.
  - Otherwise hold outputs.
- SHIFT:
  - Half-period counter runs 0..CLKDIV-1; at terminal count dac_sclk toggles.
  - On each falling toggle, shift the next bit onto dac_mosi. The DAC samples on rising edges.
  - After the 16th falling toggle (32 half-periods), dac_cs_n=1, dac_mosi=0, go to GAP.
  - dac_cs_n is low for exactly 32*CLKDIV cycles.
- GAP: hold dac_cs_n=1 for CLKDIV cycles, then go to IDLE.
- Frame timing:
  - Minimum frame period: 33*CLKDIV+1 cycles.
  - Latency from a capture tick into an empty FIFO to dac_cs_n falling: 2 cycles.
- Steady state: with SAMPLE_DIV >= 33*CLKDIV+1 the FIFO never exceeds 1 entry. Defaults give 133 <= 256.
- busy is combinational on state (IDLE -> 0).

Test Plan:
- Reset, then sample=16'sh0000, sample_active=1, defaults -> on the first tick, dac_cs_n falls 2 cycles later; 16 rising SCLK edges shift 0x8000 MSB first; dac_cs_n is low for 128 cycles.
- Samples 16'sh8000, 16'sh7FFF, 16'shFFFF captured on successive ticks -> frames carry 0x0000, 0xFFFF, 0x7FFF; fifo_level never exceeds 1.
- SAMPLE_DIV=8, CLKDIV=4, sample_active held high -> fifo_level climbs to 4; the next push while full with no concurrent pop sets overflow=1, and overflow stays 1; frames continue in order.
- Full FIFO where a push coincides with an IDLE pop -> fifo_level stays 4 and overflow stays 0.
- sample_active=0 across ticks -> no push, dac_cs_n stays 1, busy=0.
- Assert reset for 1 cycle at the 7th SCLK rise -> next edge: dac_cs_n=1, dac_sclk=0, fifo_level=0, busy=0; a new frame starts only after a fresh capture.
